// File: rtl/serial_tx.sv
// serial_tx: 8N1 serial transmitter with a PDP-8 style teleprinter interface.
// A load strobe captures data[4:11] and sends it as one start bit, eight data
// bits (data[11] first), and one stop bit, each held DIV = CLOCK_FREQ/BAUD
// clocks. The flag output signals that the previous character has been sent.
//
// Handshake: load is a one-cycle request that is honoured only when busy is 0;
// a load seen while busy is 1 is dropped. flag rises on the edge the stop bit
// completes and is cleared by an accepted load or by clear_flag.
module serial_tx #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD       = 9600
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [0:11] data,
    input  logic        load,
    input  logic        clear_flag,
    output logic        tx,
    output logic        flag,
    output logic        busy,
    output logic [1:0]  o_dbg_state
);

    localparam int DIV = CLOCK_FREQ / BAUD;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_bit_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic            r_flag;
    logic            r_busy;

    state_t          w_state_nxt;
    logic [CW-1:0]   w_bit_cnt_nxt;
    logic [2:0]      w_bit_idx_nxt;
    logic [7:0]      w_shift_nxt;
    logic            w_tx_nxt;
    logic            w_flag_nxt;
    logic            w_busy_nxt;
    logic            w_bit_end;
    logic            w_accept;
    logic            w_stop_done;

    // The top nibble of the word has no meaning for an 8-bit character.
    logic [3:0]      w_unused_hi;
    assign w_unused_hi = data[0:3];

    assign w_bit_end   = (r_bit_cnt == CNT_LAST);
    assign w_accept    = (r_state == S_IDLE) && load;
    assign w_stop_done = (r_state == S_STOP) && w_bit_end;

    // State register: every piece of sequencer state, aborted instantly by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_flag    <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            r_flag    <= w_flag_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Next-state logic: bit timing, shifting, and the next registered line level.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;

        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (load) begin
                    // Start bit goes onto the line on the same edge as the capture.
                    w_state_nxt   = S_START;
                    w_bit_cnt_nxt = '0;
                    w_bit_idx_nxt = '0;
                    w_shift_nxt   = data[4:11];
                    w_tx_nxt      = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt   = S_DATA;
                    w_bit_cnt_nxt = '0;
                    w_tx_nxt      = r_shift[0];
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_bit_cnt_nxt = '0;
                    w_shift_nxt   = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt   = S_STOP;
                        w_bit_idx_nxt = '0;
                        w_tx_nxt      = 1'b1;
                    end else begin
                        // The bit about to reach the LSB is the next one on the line.
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_tx_nxt      = r_shift[1];
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            S_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_bit_end) begin
                    w_state_nxt   = S_IDLE;
                    w_bit_cnt_nxt = '0;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_bit_cnt_nxt = '0;
                w_bit_idx_nxt = '0;
                w_tx_nxt      = 1'b1;
            end
        endcase

        // Completion of the stop bit overrides a simultaneous clear.
        w_flag_nxt = r_flag;
        if (clear_flag || w_accept) begin
            w_flag_nxt = 1'b0;
        end
        if (w_stop_done) begin
            w_flag_nxt = 1'b1;
        end

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // Output logic: all outputs come straight from registers.
    always_comb begin
        tx          = r_tx;
        flag        = r_flag;
        busy        = r_busy;
        o_dbg_state = r_state;
    end

    // Internal consistency properties of the sequencer.
    a_busy_matches_state: assert property (
        @(posedge clock) disable iff (!reset) r_busy == (r_state != S_IDLE));
    a_line_high_when_not_sending: assert property (
        @(posedge clock) disable iff (!reset)
        ((r_state == S_IDLE) || (r_state == S_STOP)) |-> r_tx);
    a_start_bit_low: assert property (
        @(posedge clock) disable iff (!reset) (r_state == S_START) |-> !r_tx);
    a_counter_in_range: assert property (
        @(posedge clock) disable iff (!reset) r_bit_cnt <= CNT_LAST);

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx at DIV = 4 (CLOCK_FREQ = 4, BAUD = 1).
module tb_serial_tx;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] data;
    logic        load;
    logic        clear_flag;
    logic        tx;
    logic        flag;
    logic        busy;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    logic       rx_en = 1'b0;
    int         rx_count = 0;

    serial_tx #(
        .CLOCK_FREQ(4),
        .BAUD(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .data(data),
        .load(load),
        .clear_flag(clear_flag),
        .tx(tx),
        .flag(flag),
        .busy(busy),
        .o_dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Driver: one full frame, sampling tx at bit centres and checking busy/flag every clock.
    task automatic run_frame(input string tag, input logic [11:0] d, input logic [9:0] exp_frame,
                             input int reload_at, input logic [11:0] d2, input int clear_at);
        logic [9:0] got;
        got = '0;
        data = d;
        load = 1'b1;
        clear_flag = (clear_at == 0);
        tick();
        load = 1'b0;
        clear_flag = 1'b0;
        check_val({tag, "_tx_c0"}, tx, 0);
        check_val({tag, "_busy_c0"}, busy, 1);
        check_val({tag, "_flag_c0"}, flag, 0);
        check_val({tag, "_state_c0"}, dbg_state, 1);
        for (int c = 1; c <= 40; c++) begin
            if (c == reload_at) begin
                data = d2;
                load = 1'b1;
            end
            if (c == clear_at) clear_flag = 1'b1;
            tick();
            load = 1'b0;
            clear_flag = 1'b0;
            if (c < 40) begin
                check_val({tag, "_busy"}, busy, 1);
                check_val({tag, "_flag"}, flag, 0);
                if (c % 4 == 2) got[c / 4] = tx;
                if (c == 4) check_val({tag, "_state_data"}, dbg_state, 2);
                if (c == 36) check_val({tag, "_state_stop"}, dbg_state, 3);
            end else begin
                check_val({tag, "_busy_end"}, busy, 0);
                check_val({tag, "_flag_end"}, flag, 1);
                check_val({tag, "_tx_end"}, tx, 1);
                check_val({tag, "_state_end"}, dbg_state, 0);
            end
        end
        check_val({tag, "_frame"}, {22'd0, got}, {22'd0, exp_frame});
    endtask

    // Scoreboard side: bench UART receiver, active during the character stream.
    initial begin
        logic [7:0] rx_byte;
        forever begin
            tick();
            if (rx_en && tx == 1'b0) begin
                repeat (2) tick();
                check_val("rx_start", tx, 0);
                for (int k = 0; k < 8; k++) begin
                    repeat (4) tick();
                    rx_byte[k] = tx;
                end
                repeat (4) tick();
                check_val("rx_stop", tx, 1);
                rx_count++;
                if (exp_q.size() == 0) begin
                    check_val("rx_unexpected", {24'd0, rx_byte}, 32'hFFFF_FFFF);
                end else begin
                    check_val("rx_char", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // Main sequence
    initial begin
        int n;
        int edges;
        logic prev_tx;

        reset = 1'b0;
        load = 1'b0;
        clear_flag = 1'b0;
        data = '0;
        #12;
        check_val("rst_tx", tx, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_flag", flag, 1);
        check_val("rst_state", dbg_state, 0);
        tick();
        reset = 1'b1;

        // First edge after release accepts; 'A' = 0,1,0,0,0,0,0,1,0,1
        run_frame("f41", 12'o0101, 10'b1010000010, -1, 12'o0000, -1);
        // Upper nibble ignored: 0xAA
        run_frame("fAA", 12'o7652, 10'b1101010100, -1, 12'o0000, -1);
        // Load at clock 12 ignored, clear mid-frame harmless
        run_frame("frel", 12'o7652, 10'b1101010100, 12, 12'o0132, 20);
        // load with clear_flag together in IDLE: 0x33
        run_frame("fldclr", 12'o0063, 10'b1001100110, -1, 12'o0000, 0);
        // clear_flag on the STOP->IDLE edge: set wins, 0x55
        run_frame("fsetwin", 12'o0125, 10'b1010101010, -1, 12'o0000, 40);

        // clear_flag in IDLE clears only the flag
        clear_flag = 1'b1;
        tick();
        clear_flag = 1'b0;
        check_val("idle_clr_flag", flag, 0);
        check_val("idle_clr_tx", tx, 1);
        check_val("idle_clr_busy", busy, 0);
        check_val("idle_clr_state", dbg_state, 0);
        tick();
        check_val("idle_clr_hold", flag, 0);

        // Reset pulsed at clock 17 of a frame
        data = 12'o0101;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (17) tick();
        check_val("mid_tx_before", tx, 0);
        reset = 1'b0;
        #1;
        check_val("mid_rst_tx", tx, 1);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_flag", flag, 1);
        check_val("mid_rst_state", dbg_state, 0);
        repeat (2) tick();
        reset = 1'b1;
        edges = 0;
        prev_tx = tx;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (tx !== prev_tx || busy !== 1'b0) edges++;
            prev_tx = tx;
        end
        check_val("post_rst_quiet", edges, 0);
        check_val("post_rst_tx", tx, 1);
        check_val("post_rst_flag", flag, 1);

        // Character stream 0x20..0x7E, load on every flag rise
        rx_en = 1'b1;
        for (int ch = 8'h20; ch <= 8'h7E; ch++) begin
            exp_q.push_back(8'(ch));
            data = {4'(ch), 8'(ch)};
            load = 1'b1;
            tick();
            load = 1'b0;
            n = 0;
            do begin
                tick();
                n++;
            end while (flag !== 1'b1 && n < 60);
            check_val("stream_len", n, 40);
        end
        repeat (4) tick();
        rx_en = 1'b0;
        check_val("stream_count", rx_count, 95);
        check_val("stream_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
